// File: rtl/io_trap_ctrl.sv
// io_trap_ctrl
// Watches Z80 I/O bus cycles (synchronised into the clk domain). When a cycle
// hits the configured trap port window it latches port, data and direction,
// fires an NMI low pulse of NMI_WIDTH clocks and holds the trap record until
// the supervisor acknowledges it.
//
// Optional build macro: IO_TRAP_COUNT_EN adds trap_count, a saturating count
// of hits dropped while a trap record is still pending.

module io_trap_ctrl #(
    parameter logic [7:0]  TRAP_BASE = 8'h40,
    parameter logic [7:0]  TRAP_MASK = 8'hF0,
    parameter int unsigned NMI_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] addr,
    input  logic [7:0] data,
    input  logic       iorq_n,
    input  logic       m1_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       io_direction,
    input  logic       new_isr,
    input  logic       trap_en,
    input  logic       trap_ack,
    output logic       nmi_n,
    output logic       trap_pending,
    output logic [7:0] trap_port,
    output logic [7:0] trap_data,
    output logic       trap_dir,
`ifdef IO_TRAP_COUNT_EN
    output logic [7:0] trap_count,
`endif
    output logic       dir_mismatch
);

    // A zero (or over-range) pulse width cannot be produced by the 8-bit counter.
    generate
        if ((NMI_WIDTH < 32'd1) || (NMI_WIDTH > 32'd255)) begin : g_bad_nmi_width
            $error("io_trap_ctrl: NMI_WIDTH must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] NMI_LOAD = NMI_WIDTH[7:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // True when the address falls in the trap window.
    function automatic logic addr_hit(input logic [7:0] a);
        return ((a & TRAP_MASK) == (TRAP_BASE & TRAP_MASK));
    endfunction

    // Synchroniser bundle order: {iorq_n, m1_n, rd_n, wr_n}
    logic [3:0] sync_meta_r;
    logic [3:0] sync_r;
    logic       iorq_s;
    logic       m1_s;
    logic       rd_s;
    logic       wr_s;

    logic       armed_r;
    logic       armed_nxt_s;
    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic       nmi_n_r;
    logic       nmi_n_nxt_s;
    logic       pending_r;
    logic       pending_nxt_s;
    logic [7:0] port_r;
    logic [7:0] port_nxt_s;
    logic [7:0] data_r;
    logic [7:0] data_nxt_s;
    logic       dir_r;
    logic       dir_nxt_s;
    logic       mismatch_r;
    logic       mismatch_nxt_s;

    logic       start_s;
    logic       hit_s;
    logic       latch_s;
    logic       drop_s;
    logic       new_dir_s;

    assign iorq_s = sync_r[3];
    assign m1_s   = sync_r[2];
    assign rd_s   = sync_r[1];
    assign wr_s   = sync_r[0];

    // Two-flop synchronisers for the asynchronous bus strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_meta_r <= 4'b1111;
            sync_r      <= 4'b1111;
        end else begin
            sync_meta_r <= {iorq_n, m1_n, rd_n, wr_n};
            sync_r      <= sync_meta_r;
        end
    end

    // Cycle-start detection: armed while IORQ is high, fires once per IORQ
    // assertion as soon as RD or WR is seen low (M1 low = interrupt ack, disarm).
    always_comb begin
        start_s     = armed_r & ~iorq_s & m1_s & (~rd_s | ~wr_s);
        hit_s       = trap_en & addr_hit(addr);
        new_dir_s   = ~rd_s;
        latch_s     = (state_r == ST_IDLE) & start_s & hit_s & ~pending_r;
        drop_s      = start_s & hit_s & pending_r;
        armed_nxt_s = armed_r;
        if (iorq_s) begin
            armed_nxt_s = 1'b1;
        end else if (start_s || !m1_s) begin
            armed_nxt_s = 1'b0;
        end else begin
            armed_nxt_s = armed_r;
        end
    end

    // Next-state, pulse counter and trap record update.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        nmi_n_nxt_s    = nmi_n_r;
        port_nxt_s     = port_r;
        data_nxt_s     = data_r;
        dir_nxt_s      = dir_r;
        pending_nxt_s  = pending_r;
        mismatch_nxt_s = mismatch_r;

        case (state_r)
            ST_IDLE: begin
                nmi_n_nxt_s = 1'b1;
                if (latch_s) begin
                    state_nxt_s = ST_PULSE;
                    nmi_n_nxt_s = 1'b0;
                    cnt_nxt_s   = NMI_LOAD;
                    port_nxt_s  = addr;
                    dir_nxt_s   = new_dir_s;
                    data_nxt_s  = new_dir_s ? 8'h00 : data;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PULSE: begin
                nmi_n_nxt_s = 1'b0;
                if (cnt_r == 8'd1) begin
                    state_nxt_s = ST_HOLD;
                    nmi_n_nxt_s = 1'b1;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s   = cnt_r - 8'd1;
                end
            end
            ST_HOLD: begin
                nmi_n_nxt_s = 1'b1;
                if (iorq_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                nmi_n_nxt_s = 1'b1;
                cnt_nxt_s   = 8'd0;
            end
        endcase

        // A new latch beats a simultaneous acknowledge.
        if (latch_s) begin
            pending_nxt_s = 1'b1;
        end else if (trap_ack) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end

        // Prediction is only trusted at an instruction start.
        if (latch_s && new_isr && (io_direction != new_dir_s)) begin
            mismatch_nxt_s = 1'b1;
        end else if (trap_ack) begin
            mismatch_nxt_s = 1'b0;
        end else begin
            mismatch_nxt_s = mismatch_r;
        end
    end

    // Control state, arming flag and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed_r    <= 1'b1;
            state_r    <= ST_IDLE;
            cnt_r      <= 8'd0;
            nmi_n_r    <= 1'b1;
            pending_r  <= 1'b0;
            port_r     <= 8'h00;
            data_r     <= 8'h00;
            dir_r      <= 1'b0;
            mismatch_r <= 1'b0;
        end else begin
            armed_r    <= armed_nxt_s;
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            nmi_n_r    <= nmi_n_nxt_s;
            pending_r  <= pending_nxt_s;
            port_r     <= port_nxt_s;
            data_r     <= data_nxt_s;
            dir_r      <= dir_nxt_s;
            mismatch_r <= mismatch_nxt_s;
        end
    end

`ifdef IO_TRAP_COUNT_EN
    logic [7:0] count_r;
    logic [7:0] count_nxt_s;

    // Saturating count of dropped hits; a drop alongside an ack counts as one.
    always_comb begin
        count_nxt_s = count_r;
        if (drop_s && trap_ack) begin
            count_nxt_s = 8'd1;
        end else if (trap_ack) begin
            count_nxt_s = 8'd0;
        end else if (drop_s && (count_r != 8'hFF)) begin
            count_nxt_s = count_r + 8'd1;
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Dropped-hit counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 8'd0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign trap_count = count_r;
`else
    logic unused_drop_s;
    assign unused_drop_s = drop_s;
`endif

    assign nmi_n        = nmi_n_r;
    assign trap_pending = pending_r;
    assign trap_port    = port_r;
    assign trap_data    = data_r;
    assign trap_dir     = dir_r;
    assign dir_mismatch = mismatch_r;

endmodule

// File: tb/tb_io_trap_ctrl.sv
// Directed testbench for io_trap_ctrl (default parameters: window 0x40-0x4F,
// NMI_WIDTH = 8). Bus strobes change 1 ns after a rising edge; outputs are
// checked on falling edges.

module tb_io_trap_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] addr;
    logic [7:0] data;
    logic       iorq_n;
    logic       m1_n;
    logic       rd_n;
    logic       wr_n;
    logic       io_direction;
    logic       new_isr;
    logic       trap_en;
    logic       trap_ack;
    logic       nmi_n;
    logic       trap_pending;
    logic [7:0] trap_port;
    logic [7:0] trap_data;
    logic       trap_dir;
    logic       dir_mismatch;
`ifdef IO_TRAP_COUNT_EN
    logic [7:0] trap_count;
`endif

    int vectors;
    int miscompares;
    int lows;
    int first_low;

    io_trap_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .addr         (addr),
        .data         (data),
        .iorq_n       (iorq_n),
        .m1_n         (m1_n),
        .rd_n         (rd_n),
        .wr_n         (wr_n),
        .io_direction (io_direction),
        .new_isr      (new_isr),
        .trap_en      (trap_en),
        .trap_ack     (trap_ack),
        .nmi_n        (nmi_n),
        .trap_pending (trap_pending),
        .trap_port    (trap_port),
        .trap_data    (trap_data),
        .trap_dir     (trap_dir),
`ifdef IO_TRAP_COUNT_EN
        .trap_count   (trap_count),
`endif
        .dir_mismatch (dir_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start an I/O cycle just after a rising edge.
    task automatic drive_io(input logic [7:0] p, input logic [7:0] d, input logic is_in);
        @(posedge clk);
        #1;
        addr   = p;
        data   = d;
        m1_n   = 1'b1;
        iorq_n = 1'b0;
        rd_n   = ~is_in;
        wr_n   = is_in;
    endtask

    // End the I/O cycle and let the synchronisers / HOLD state settle.
    task automatic end_io();
        @(posedge clk);
        #1;
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        m1_n   = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Observe nmi_n on 14 falling edges; optionally pulse trap_ack once.
    task automatic watch_nmi(input int ack_at, output int n_low, output int first);
        n_low = 0;
        first = -1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (nmi_n === 1'b0) begin
                n_low++;
                if (first < 0) first = i;
            end
            trap_ack = (i == ack_at) ? 1'b1 : 1'b0;
        end
        trap_ack = 1'b0;
    endtask

    task automatic ack_pulse();
        @(posedge clk);
        #1;
        trap_ack = 1'b1;
        @(posedge clk);
        #1;
        trap_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        reset_n      = 1'b0;
        addr         = 8'h00;
        data         = 8'h00;
        iorq_n       = 1'b1;
        m1_n         = 1'b1;
        rd_n         = 1'b1;
        wr_n         = 1'b1;
        io_direction = 1'b0;
        new_isr      = 1'b1;
        trap_en      = 1'b1;
        trap_ack     = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_nmi_n", nmi_n, 1'b1);
        chk("rst_pending", trap_pending, 1'b0);
        chk("rst_port", trap_port, 8'h00);
        chk("rst_data", trap_data, 8'h00);
        chk("rst_dir", trap_dir, 1'b0);
        chk("rst_mismatch", dir_mismatch, 1'b0);
`ifdef IO_TRAP_COUNT_EN
        chk("rst_count", trap_count, 8'd0);
`endif
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // OUT (0x42), 0x5A: pulse starts 3 clocks after the fall, lasts 8
        io_direction = 1'b0;
        new_isr      = 1'b1;
        drive_io(8'h42, 8'h5A, 1'b0);
        watch_nmi(0, lows, first_low);
        chk("out42_first_low", first_low, 32'd4);
        chk("out42_low_len", lows, 32'd8);
        chk("out42_port", trap_port, 8'h42);
        chk("out42_data", trap_data, 8'h5A);
        chk("out42_dir", trap_dir, 1'b0);
        chk("out42_pending", trap_pending, 1'b1);
        chk("out42_mismatch", dir_mismatch, 1'b0);
        end_io();

        // Second hit before ack is dropped
        drive_io(8'h43, 8'h11, 1'b0);
        watch_nmi(0, lows, first_low);
        chk("drop_low_len", lows, 32'd0);
        chk("drop_port", trap_port, 8'h42);
        chk("drop_data", trap_data, 8'h5A);
        chk("drop_pending", trap_pending, 1'b1);
`ifdef IO_TRAP_COUNT_EN
        chk("drop_count", trap_count, 8'd1);
`endif
        end_io();

        // Ack clears pending, record kept
        ack_pulse();
        chk("ack1_pending", trap_pending, 1'b0);
        chk("ack1_port", trap_port, 8'h42);
`ifdef IO_TRAP_COUNT_EN
        chk("ack1_count", trap_count, 8'd0);
`endif

        // New trap after ack
        drive_io(8'h44, 8'h77, 1'b0);
        watch_nmi(0, lows, first_low);
        chk("out44_first_low", first_low, 32'd4);
        chk("out44_low_len", lows, 32'd8);
        chk("out44_port", trap_port, 8'h44);
        chk("out44_data", trap_data, 8'h77);
        chk("out44_pending", trap_pending, 1'b1);
        end_io();
        ack_pulse();

        // IN from 0x4F with OUT predicted -> mismatch
        io_direction = 1'b0;
        new_isr      = 1'b1;
        drive_io(8'h4F, 8'hAB, 1'b1);
        watch_nmi(0, lows, first_low);
        chk("in4f_low_len", lows, 32'd8);
        chk("in4f_port", trap_port, 8'h4F);
        chk("in4f_dir", trap_dir, 1'b1);
        chk("in4f_data", trap_data, 8'h00);
        chk("in4f_mismatch", dir_mismatch, 1'b1);
        chk("in4f_pending", trap_pending, 1'b1);
        end_io();
        ack_pulse();
        chk("ack2_pending", trap_pending, 1'b0);
        chk("ack2_mismatch", dir_mismatch, 1'b0);

        // Miss outside the window
        drive_io(8'h80, 8'h01, 1'b0);
        watch_nmi(0, lows, first_low);
        chk("miss80_low_len", lows, 32'd0);
        chk("miss80_pending", trap_pending, 1'b0);
        end_io();

        // Trap disabled
        trap_en = 1'b0;
        drive_io(8'h42, 8'h02, 1'b0);
        watch_nmi(0, lows, first_low);
        chk("dis42_low_len", lows, 32'd0);
        chk("dis42_pending", trap_pending, 1'b0);
        end_io();
        trap_en = 1'b1;

        // Interrupt acknowledge: M1 and IORQ low together
        @(posedge clk);
        #1;
        addr   = 8'h40;
        m1_n   = 1'b0;
        iorq_n = 1'b0;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        watch_nmi(0, lows, first_low);
        chk("intack_low_len", lows, 32'd0);
        chk("intack_pending", trap_pending, 1'b0);
        end_io();

        // Mismatch suppressed when new_isr = 0
        io_direction = 1'b0;
        new_isr      = 1'b0;
        drive_io(8'h45, 8'hCD, 1'b1);
        watch_nmi(0, lows, first_low);
        chk("in45_low_len", lows, 32'd8);
        chk("in45_dir", trap_dir, 1'b1);
        chk("in45_mismatch", dir_mismatch, 1'b0);
        chk("in45_pending", trap_pending, 1'b1);
        end_io();
        ack_pulse();
        new_isr = 1'b1;

        // Ack mid-pulse does not shorten it
        drive_io(8'h46, 8'h3C, 1'b0);
        watch_nmi(6, lows, first_low);
        chk("ackmid_first_low", first_low, 32'd4);
        chk("ackmid_low_len", lows, 32'd8);
        chk("ackmid_pending", trap_pending, 1'b0);
        chk("ackmid_port", trap_port, 8'h46);
        end_io();

        // Reset during the pulse
        drive_io(8'h41, 8'h99, 1'b0);
        repeat (6) @(negedge clk);
        chk("rstmid_nmi_before", nmi_n, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rstmid_nmi_n", nmi_n, 1'b1);
        chk("rstmid_pending", trap_pending, 1'b0);
        chk("rstmid_port", trap_port, 8'h00);
        chk("rstmid_data", trap_data, 8'h00);
        chk("rstmid_dir", trap_dir, 1'b0);
        chk("rstmid_mismatch", dir_mismatch, 1'b0);
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fresh trap after reset
        drive_io(8'h41, 8'h99, 1'b0);
        watch_nmi(0, lows, first_low);
        chk("post_rst_first_low", first_low, 32'd4);
        chk("post_rst_low_len", lows, 32'd8);
        chk("post_rst_port", trap_port, 8'h41);
        chk("post_rst_data", trap_data, 8'h99);
        chk("post_rst_pending", trap_pending, 1'b1);
        end_io();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/io_trap_ctrl.md
Name: io_trap_ctrl

Overview:
- Downstream consumer of the opcode tracker's `io_direction` and `new_isr` outputs.
- Watches Z80 I/O bus cycles, sampled in the `clk` domain.
- When a cycle hits the configured trap port window, latches port, data and direction, then fires a timed NMI pulse so the MegaMapper supervisor can emulate the access.
- Holds the trap record until the supervisor acknowledges it.

Parameters:
- TRAP_BASE, 8'h40, base I/O port of the trap window (low address byte).
- TRAP_MASK, 8'hF0, address bits compared against TRAP_BASE; 1 = compared.
- NMI_WIDTH, 8, NMI low-pulse length in clk cycles (1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- addr  in  8  Z80 A[7:0]
- data  in  8  Z80 D[7:0]
- iorq_n  in  1  Z80 IORQ, async
- m1_n  in  1  Z80 M1, async
- rd_n  in  1  Z80 RD, async
- wr_n  in  1  Z80 WR, async
- io_direction  in  1  predicted direction from the opcode tracker; 1 = IN, 0 = OUT
- new_isr  in  1  opcode tracker: current opcode is instruction start
- trap_en  in  1  global trap enable, synchronous level
- trap_ack  in  1  supervisor acknowledge, one clk pulse
- nmi_n  out  1  NMI request, active low
- trap_pending  out  1  valid trap record held
- trap_port  out  8  latched port
- trap_data  out  8  latched write data; 0 for IN
- trap_dir  out  1  latched direction; 1 = IN
- dir_mismatch  out  1  sticky: io_direction disagreed with RD/WR on a trapped cycle

Behaviour:
- Reset is asynchronous, active-low, and always honoured.
  - Reset values: nmi_n = 1, trap_pending = 0, trap_port = 0, trap_data = 0, trap_dir = 0, dir_mismatch = 0, state = IDLE, synchronisers = all ones.
  - Reset mid-pulse ends the NMI immediately.
- Input sync: `iorq_n`, `m1_n`, `rd_n` and `wr_n` each pass through a 2-flop synchroniser. All decisions use the synchronised values (2-cycle latency).
- IO cycle start is one clk cycle where all of the following hold:
  - synchronised `iorq_n` goes 1 -> 0,
  - synchronised `m1_n` = 1, which excludes interrupt acknowledge,
  - (rd_n == 0 or wr_n == 0).
  - If RD and WR are both high at the IORQ edge, re-evaluate each cycle while IORQ stays low. The start fires once per IORQ assertion.
- Hit condition: `trap_en` = 1 and (addr & TRAP_MASK) == (TRAP_BASE & TRAP_MASK).
- State machine:
  - IDLE
    - Cycle start with hit and trap_pending = 0 -> latch the record, go to PULSE.
    - Latched record: trap_port = addr, trap_dir = !rd_n_s ? 1 : 0, trap_data = data if OUT else 8'h00.
    - Set trap_pending = 1.
    - Set dir_mismatch = 1 if io_direction != trap_dir.
    - Load the counter with NMI_WIDTH.
    - Hit while trap_pending = 1: the cycle is dropped, no state change.
  - PULSE: nmi_n = 0. Decrement the counter each cycle. At count 1, go to HOLD. Pulse length is exactly NMI_WIDTH cycles.
  - HOLD: nmi_n = 1. Wait for synchronised iorq_n = 1, then go to IDLE. This prevents re-trigger within the same bus cycle.
- trap_ack:
  - Clears trap_pending in any state; the record fields keep their values.
  - Clears dir_mismatch.
  - Ack arriving in the same cycle as a new latch: the latch wins and trap_pending = 1.
  - Ack during PULSE does not shorten the pulse.
- new_isr is not used for decode. It qualifies mismatch only: dir_mismatch is not set when new_isr = 0, because the prefix byte sequence is still in progress and the prediction is stale.
- Counter: 8-bit. NMI_WIDTH = 0 is illegal and must be flagged by an elaboration check.

Optional Feature:
- Macro: IO_TRAP_COUNT_EN.
- Defined:
  - Adds output trap_count [7:0], a saturating count of dropped hits (hits while trap_pending = 1).
  - Reset value 0. Sticks at 8'hFF. Cleared by trap_ack.
  - Ack and drop in the same cycle -> count = 1.
- Undefined: the port and counter are absent; dropped hits are silently ignored.

Test Plan:
- OUT (0x42), 0x5A with io_direction = 0, new_isr = 1 -> nmi_n low for exactly 8 clks starting 3 clks after WR/IORQ fall. Record: trap_port = 0x42, trap_data = 0x5A, trap_dir = 0, trap_pending = 1, dir_mismatch = 0.
- IN from port 0x4F with io_direction = 0 -> trap_dir = 1, trap_data = 0x00, dir_mismatch = 1. trap_ack pulse -> trap_pending = 0 and dir_mismatch = 0.
- OUT to 0x80 with trap_en = 1, and OUT to 0x42 with trap_en = 0 -> no NMI, trap_pending stays 0.
- Interrupt acknowledge (M1 low with IORQ low, addr = 0x40) -> no trap.
- Second hit on 0x43 before ack:
  - No second NMI; record still shows 0x42.
  - With IO_TRAP_COUNT_EN, trap_count = 1.
  - Ack, then OUT 0x44 -> new trap fires.
- reset_n asserted during PULSE -> nmi_n = 1 asynchronously and all outputs at reset values. After release, a fresh OUT 0x41 traps normally.
